// File: rtl/ram_uart_gonderici_if.sv
// RAM read port and UART TX register port between the image sender and its neighbours.
// The master drives address/enable and the TX strobe; the slave returns read data and TX status.
interface ram_uart_gonderici_if #(
    parameter int A = 17,
    parameter int V = 8
);
    logic         ram_en_o;
    logic         ram_we_o;
    logic [A-1:0] ram_addr_o;
    logic [V-1:0] ram_data_i;
    logic         tx_active_o;
    logic         tx_wenable_o;
    logic [7:0]   tx_wdata_o;
    logic         tx_full_i;
    logic         tx_sent_i;

    modport master (
        output ram_en_o, ram_we_o, ram_addr_o,
        input  ram_data_i,
        output tx_active_o, tx_wenable_o, tx_wdata_o,
        input  tx_full_i, tx_sent_i
    );

    modport slave (
        input  ram_en_o, ram_we_o, ram_addr_o,
        output ram_data_i,
        input  tx_active_o, tx_wenable_o, tx_wdata_o,
        output tx_full_i, tx_sent_i
    );
endinterface

// File: rtl/ram_uart_gonderici.sv
// Streams DEGER bytes from the output RAM into the UART TX FIFO, one byte per "sent" pulse,
// optionally followed by an 8-bit additive checksum; 3 cycles from start to first strobe.
module ram_uart_gonderici #(
    parameter int DEGER       = 76800,
    parameter int A           = 17,
    parameter int V           = 8,
    parameter int CHECKSUM_EN = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    ram_uart_gonderici_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [A:0]           sent_count_o,
    output logic [7:0]           checksum_o
);
    typedef enum logic [2:0] {
        IDLE, READ, CAPTURE, LOAD, SENT_WAIT, CSUM, DONE
    } state_t;

    localparam logic [A:0]   DEGER_W  = (A+1)'(DEGER);
    localparam logic [A:0]   CNT_ONE  = (A+1)'(1);
    localparam logic [A-1:0] ADDR_ONE = A'(1);

    state_t       state_q, state_d;
    logic [A-1:0] addr_q, addr_d;
    logic [7:0]   wdata_q, wdata_d;
    logic [A:0]   img_cnt_q, img_cnt_d;
    logic [A:0]   sent_q, sent_d;
    logic [7:0]   csum_q, csum_d;
    logic         csum_phase_q, csum_phase_d;
    logic         wenable;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            img_cnt_q    <= '0;
            sent_q       <= '0;
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            img_cnt_q    <= img_cnt_d;
            sent_q       <= sent_d;
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        img_cnt_d    = img_cnt_q;
        sent_d       = sent_q;
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
        wenable      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d      = READ;
                    addr_d       = '0;
                    img_cnt_d    = '0;
                    sent_d       = '0;
                    csum_d       = '0;
                    csum_phase_d = 1'b0;
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: begin
                wdata_d = bus.ram_data_i[7:0];
                state_d = LOAD;
            end
            LOAD: begin
                if (!bus.tx_full_i) begin
                    wenable = 1'b1;
                    state_d = SENT_WAIT;
                end
            end
            SENT_WAIT: begin
                if (bus.tx_sent_i) begin
                    sent_d = sent_q + CNT_ONE;
                    if (csum_phase_q) begin
                        state_d = DONE;
                    end else begin
                        csum_d    = csum_q + wdata_q;
                        img_cnt_d = img_cnt_q + CNT_ONE;
                        // Address only advances while more image bytes remain, so it stops at DEGER-1.
                        if (img_cnt_d < DEGER_W) begin
                            addr_d  = addr_q + ADDR_ONE;
                            state_d = READ;
                        end else if (CHECKSUM_EN != 0) begin
                            state_d = CSUM;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            CSUM: begin
                wdata_d      = csum_q;
                csum_phase_d = 1'b1;
                state_d      = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o           = (state_q != IDLE) && (state_q != DONE);
    assign done_o           = (state_q == DONE);
    assign sent_count_o     = sent_q;
    assign checksum_o       = csum_q;
    assign bus.ram_en_o     = busy_o;
    assign bus.ram_we_o     = 1'b0;
    assign bus.ram_addr_o   = addr_q;
    assign bus.tx_active_o  = busy_o;
    assign bus.tx_wenable_o = wenable;
    assign bus.tx_wdata_o   = wdata_q;
endmodule

// File: tb/tb_ram_uart_gonderici.sv
// Directed bench driving a checksum-less and a checksum-enabled sender in lockstep.
module tb_ram_uart_gonderici;
    localparam int DEGER = 4;
    localparam int A     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start;
    logic       busy0, done0, busy1, done1;
    logic [A:0] cnt0, cnt1;
    logic [7:0] cs0, cs1;

    ram_uart_gonderici_if #(.A(A), .V(8)) bus0 ();
    ram_uart_gonderici_if #(.A(A), .V(8)) bus1 ();

    ram_uart_gonderici #(.DEGER(DEGER), .A(A), .V(8), .CHECKSUM_EN(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .bus(bus0),
        .busy_o(busy0), .done_o(done0), .sent_count_o(cnt0), .checksum_o(cs0)
    );
    ram_uart_gonderici #(.DEGER(DEGER), .A(A), .V(8), .CHECKSUM_EN(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .bus(bus1),
        .busy_o(busy1), .done_o(done1), .sent_count_o(cnt1), .checksum_o(cs1)
    );

    logic [7:0] mem [0:15];
    always @(posedge clk) begin
        if (bus0.ram_en_o) bus0.ram_data_i <= mem[bus0.ram_addr_o];
        if (bus1.ram_en_o) bus1.ram_data_i <= mem[bus1.ram_addr_o];
    end

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         cd [2];
    int         nstrobe [2];
    int         npulse [2];
    int         last_pulse_cyc [2];
    logic       strobe_now [2];
    logic [7:0] wdata_now [2];
    logic       sent_now [2];
    logic       stray;
    logic [7:0] exp_cs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples strobes mid-cycle, drives the TX "sent" responder, then advances one clock.
    task automatic tick();
        logic       we [2];
        logic [7:0] wd [2];
        logic       p;
        #2;
        we[0] = bus0.tx_wenable_o; we[1] = bus1.tx_wenable_o;
        wd[0] = bus0.tx_wdata_o;   wd[1] = bus1.tx_wdata_o;
        for (int k = 0; k < 2; k++) begin
            p = 1'b0;
            if (cd[k] > 0) begin
                cd[k]--;
                if (cd[k] == 0) p = 1'b1;
            end
            if (p) begin
                npulse[k]++;
                last_pulse_cyc[k] = cyc;
            end
            sent_now[k]   = p | stray;
            strobe_now[k] = we[k];
            wdata_now[k]  = wd[k];
            if (we[k]) begin
                nstrobe[k]++;
                cd[k] = 5;
                if (k == 0) begin
                    chk("sb0_nonempty", 32'(exp_q0.size() != 0), 1);
                    if (exp_q0.size() != 0) chk("sb0_data", wd[0], exp_q0.pop_front());
                end else begin
                    chk("sb1_nonempty", 32'(exp_q1.size() != 0), 1);
                    if (exp_q1.size() != 0) chk("sb1_data", wd[1], exp_q1.pop_front());
                end
            end
        end
        bus0.tx_sent_i = sent_now[0];
        bus1.tx_sent_i = sent_now[1];
        stray = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_run();
        for (int k = 0; k < 2; k++) begin
            nstrobe[k] = 0;
            npulse[k]  = 0;
        end
        for (int i = 0; i < DEGER; i++) begin
            exp_q0.push_back(mem[i]);
            exp_q1.push_back(mem[i]);
        end
        exp_q1.push_back(exp_cs);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int   n;
        logic prev0, prev1;
        n = 0;
        prev0 = done0;
        prev1 = done1;
        while (!(done0 && done1) && n < budget) begin
            tick();
            n++;
            if (done0 && !prev0) chk("done0_latency", cyc - last_pulse_cyc[0], 1);
            if (done1 && !prev1) begin
                chk("done1_latency", cyc - last_pulse_cyc[1], 1);
                chk("done1_after_fifth_sent", npulse[1], DEGER + 1);
            end
            prev0 = done0;
            prev1 = done1;
        end
        chk("done_within_budget", 32'(done0 && done1), 1);
    endtask

    task automatic end_checks();
        chk("q0_drained", exp_q0.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);
        chk("strobes0", nstrobe[0], DEGER);
        chk("strobes1", nstrobe[1], DEGER + 1);
        chk("sent_count0", cnt0, DEGER);
        chk("sent_count1", cnt1, DEGER + 1);
        chk("checksum0", cs0, exp_cs);
        chk("checksum1", cs1, exp_cs);
        chk("busy0_done", busy0, 0);
        chk("tx_active1_done", bus1.tx_active_o, 0);
        chk("ram_en1_done", bus1.ram_en_o, 0);
    endtask

    task automatic check_reset();
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cs0", cs0, 0);
        chk("rst_ram_en0", bus0.ram_en_o, 0);
        chk("rst_ram_we0", bus0.ram_we_o, 0);
        chk("rst_addr0", bus0.ram_addr_o, 0);
        chk("rst_tx_active0", bus0.tx_active_o, 0);
        chk("rst_wenable0", bus0.tx_wenable_o, 0);
        chk("rst_wdata0", bus0.tx_wdata_o, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_wdata1", bus1.tx_wdata_o, 0);
    endtask

    initial begin
        int n;
        rstn  = 1'b0;
        start = 1'b0;
        stray = 1'b0;
        bus0.tx_full_i = 1'b0; bus0.tx_sent_i = 1'b0;
        bus1.tx_full_i = 1'b0; bus1.tx_sent_i = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hF5;
        exp_cs = 8'h00;
        for (int i = 0; i < DEGER; i++) exp_cs = exp_cs + mem[i];
        for (int k = 0; k < 2; k++) begin
            cd[k] = 0; nstrobe[k] = 0; npulse[k] = 0; last_pulse_cyc[k] = 0;
            strobe_now[k] = 1'b0; wdata_now[k] = 8'h00; sent_now[k] = 1'b0;
        end

        repeat (3) tick();
        check_reset();
        rstn = 1'b1;
        tick();

        // Basic transfer with start-to-strobe timing
        begin_run();
        chk("start_addr", bus0.ram_addr_o, 0);
        chk("start_ram_en", bus0.ram_en_o, 1);
        chk("start_tx_active", bus0.tx_active_o, 1);
        chk("start_busy", busy0, 1);
        tick();
        chk("we_t1", strobe_now[0], 0);
        tick();
        chk("we_t2", strobe_now[0], 0);
        tick();
        chk("we_t3", strobe_now[0], 1);
        chk("we_t3_data", wdata_now[0], 8'h10);
        wait_done(300);
        end_checks();

        // Restart from DONE
        repeat (3) tick();
        begin_run();
        chk("restart_done0", done0, 0);
        chk("restart_done1", done1, 0);
        chk("restart_cs0", cs0, 0);
        chk("restart_cs1", cs1, 0);
        chk("restart_cnt1", cnt1, 0);
        wait_done(300);
        end_checks();

        // Backpressure on byte 2, then a stray sent in READ and a start mid-transfer
        begin_run();
        n = 0;
        while (nstrobe[0] < 1 && n < 50) begin tick(); n++; end
        chk("bp_first_strobe", nstrobe[0], 1);
        bus0.tx_full_i = 1'b1;
        bus1.tx_full_i = 1'b1;
        repeat (7) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_no_strobe", strobe_now[0], 0);
            chk("bp_wdata_held", wdata_now[0], 8'h20);
        end
        bus0.tx_full_i = 1'b0;
        bus1.tx_full_i = 1'b0;
        tick();
        chk("bp_release_strobe", strobe_now[0], 1);
        chk("bp_release_data", wdata_now[0], 8'h20);
        n = 0;
        while (!sent_now[0] && n < 20) begin tick(); n++; end
        chk("bp_sent_seen", sent_now[0], 1);
        stray = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stray_cnt", cnt0, 2);
        chk("stray_addr", bus0.ram_addr_o, 2);
        chk("stray_busy", busy0, 1);
        wait_done(300);
        end_checks();

        // Reset while byte 2 is in flight, then resend from address 0
        repeat (2) tick();
        begin_run();
        n = 0;
        while (nstrobe[0] < 2 && n < 50) begin tick(); n++; end
        chk("mid_second_strobe", nstrobe[0], 2);
        rstn = 1'b0;
        tick();
        check_reset();
        rstn = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        cd[0] = 0;
        cd[1] = 0;
        tick();
        begin_run();
        chk("resend_addr", bus0.ram_addr_o, 0);
        wait_done(300);
        end_checks();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_uart_gonderici.md
# ram_uart_gonderici

- Downstream stage of the image-processing top level.
- Streams a fixed-length result image, DEGER bytes, out of the synchronous output RAM into the UART transmitter's register interface.
- Sends one byte at a time and waits for the transmitter's per-byte "sent" pulse before fetching the next byte.
- Can append an 8-bit additive checksum byte, and signals completion to the top-level sequencer.

## Interface
- DEGER, 76800: number of image bytes to send; must be ≥ 1.
- A, 17: RAM address width; 2^A ≥ DEGER.
- V, 8: RAM data width; fixed at 8 for UART.
- CHECKSUM_EN, 1: when 1, one checksum byte is appended after the image.

- clk_i  in  1  system clock; all logic on posedge.
- rstn_i  in  1  reset; synchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE or DONE.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable; constant 0.
- ram_addr_o  out  A  RAM read address.
- ram_data_i  in  V  RAM read data; valid the cycle after the address cycle.
- tx_active_o  out  1  drives UART_Kontrol_Yazmaci_tx_Active.
- tx_wenable_o  out  1  one-cycle write strobe into the TX FIFO.
- tx_wdata_o  out  8  byte presented with tx_wenable_o.
- tx_full_i  in  1  TX FIFO full.
- tx_sent_i  in  1  one-cycle pulse: the current byte has left the serializer.
- busy_o  out  1  high outside IDLE and DONE.
- done_o  out  1  high while in DONE.
- sent_count_o  out  A+1  number of bytes acknowledged so far, checksum byte included.
- checksum_o  out  8  running mod-256 sum of the image bytes.

## Operation
States: IDLE, READ, CAPTURE, LOAD, SENT_WAIT, CSUM, DONE.

- **Reset** (rstn_i=0 at a posedge) forces the following, from any state including mid-transfer:
  - state IDLE;
  - ram_en_o=0, ram_we_o=0, ram_addr_o=0;
  - tx_active_o=0, tx_wenable_o=0, tx_wdata_o=0;
  - busy_o=0, done_o=0, sent_count_o=0, checksum_o=0;
  - the byte counter cleared.
- **IDLE / DONE + start_i=1** → READ.
  - Clears the counter, sent_count_o and checksum_o.
  - Sets ram_addr_o=0, ram_en_o=1, tx_active_o=1.
  - done_o drops.
- **READ**: RAM samples ram_addr_o → CAPTURE.
- **CAPTURE**: latch ram_data_i into tx_wdata_o → LOAD.
- **LOAD**:
  - If tx_full_i=0: assert tx_wenable_o for exactly one cycle → SENT_WAIT.
  - Otherwise hold in LOAD with tx_wenable_o=0 and tx_wdata_o stable.
- **SENT_WAIT**: wait for tx_sent_i=1. On that cycle:
  - sent_count_o += 1;
  - if an image byte: checksum_o += tx_wdata_o (mod 256);
  - if image bytes sent < DEGER: ram_addr_o += 1 → READ;
  - else if CHECKSUM_EN=1 and checksum not yet sent → CSUM;
  - else → DONE.
- **CSUM**: tx_wdata_o ← checksum_o (final value) → LOAD. The checksum byte follows the same LOAD/SENT_WAIT handshake.
- **DONE**:
  - tx_active_o=0, ram_en_o=0, done_o=1.
  - Hold until start_i, which restarts the transfer.
- start_i is ignored while busy_o=1.
- tx_sent_i is ignored outside SENT_WAIT; a stray pulse must not advance any counter.
- Address arithmetic: ram_addr_o never exceeds DEGER-1 and never wraps. The last image address is DEGER-1.
- Checksum arithmetic: 8-bit wrap-around sum, carry discarded.

## Timing
- start_i seen at edge t:
  - READ at t+1 with ram_addr_o=0;
  - CAPTURE at t+2;
  - LOAD at t+3;
  - earliest tx_wenable_o=1 during t+3.
- Per-byte overhead outside the UART: 4 cycles from tx_sent_i to the next tx_wenable_o (SENT_WAIT→READ→CAPTURE→LOAD).
- Total cycles ≥ DEGER×(4 + UART byte time) + 3 with no checksum. CHECKSUM_EN adds 2 + one byte time.
- tx_wdata_o is stable from the CAPTURE cycle until the next CAPTURE or CSUM cycle.
- At most one tx_wenable_o per tx_sent_i.
- tx_sent_i in the same cycle tx_wenable_o is asserted is ignored, since the state is LOAD and not yet SENT_WAIT.
- done_o rises the cycle after the final tx_sent_i.

## Test plan
- **Basic transfer.** DEGER=4, CHECKSUM_EN=0, RAM={0x10,0x20,0x30,0xF5}, tx_sent_i pulsed 5 cycles after each wenable.
  - Expect exactly 4 strobes with data 0x10,0x20,0x30,0xF5.
  - Expect done_o=1, sent_count_o=4, checksum_o=0x55.
- **Checksum byte.** Same setup with CHECKSUM_EN=1.
  - Expect a fifth strobe with data 0x55.
  - Expect sent_count_o=5; done_o only after the fifth tx_sent_i.
- **FIFO full backpressure.** tx_full_i=1 for 10 cycles when the second byte reaches LOAD.
  - Expect no strobe during those cycles and tx_wdata_o held at 0x20.
  - Expect a strobe on the first cycle tx_full_i=0.
- **Ignored inputs.** A stray tx_sent_i during READ, and start_i mid-transfer.
  - Expect no change in count, address or sequence.
- **Reset mid-operation.** rstn_i=0 for 1 cycle while sending byte 2.
  - Expect all outputs at reset values next cycle and state IDLE.
  - A new start_i must resend from address 0.
- **Restart from DONE.** start_i in DONE.
  - Expect done_o=0 next cycle and a full identical resend with a freshly cleared checksum_o.
